// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter, one frame per level-held request, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit7 and the stop bit(s).
module uart_tx #(
  parameter int CLKS_PER_BIT = 96,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_send,
  input  logic [7:0] send_data,
  output logic       uart_send_done,
  output logic       txd,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic [7:0]    shreg;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign bit_end = (baud_cnt == BAUD_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= 1'b0;
      shreg          <= '0;
      txd            <= 1'b1;
      tx_busy        <= 1'b0;
      uart_send_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par            <= 1'b0;
`endif
    end else begin
      uart_send_done <= 1'b0;
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          if (uart_send) begin
            shreg    <= send_data;
            bit_cnt  <= '0;
            txd      <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            par      <= ^send_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            txd      <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd      <= par;
              state    <= PARITY;
`else
              txd      <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            txd      <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // stop_cnt extends the high level to STOP_BITS whole bit periods
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              uart_send_done <= 1'b1;
              state          <= DONE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DONE: begin
          txd      <= 1'b1;
          tx_busy  <= 1'b0;
          baud_cnt <= '0;
          state    <= IDLE;
        end
        default: begin
          txd     <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: waveform, busy/done timing, back-to-back, abort cases.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 10 + P;
  localparam int FLEN  = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_send = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       uart_send_done, txd, tx_busy;

  int checks = 0;
  int failures = 0;
  logic txd_q[$];
  logic done_q[$];
  logic busy_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .uart_send(uart_send), .send_data(send_data),
    .uart_send_done(uart_send_done), .txd(txd), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample outputs mid-cycle and log them
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      txd_q.push_back(txd);
      done_q.push_back(uart_send_done);
      busy_q.push_back(tx_busy);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (P == 1 && k == 9) return ^d;
    return 1'b1;
  endfunction

  // s = log index of the first start-bit sample (cycle after launch edge)
  task automatic check_frame(input string tag, input int s, input logic [7:0] d);
    if (s + FLEN + 1 >= txd_q.size()) begin
      chk({tag, "_truncated"}, txd_q.size(), s + FLEN + 2);
      return;
    end
    for (int j = 0; j < FLEN; j++) begin
      chk($sformatf("%s_txd_c%0d", tag, j), txd_q[s+j], exp_bit(d, j / CPB));
      chk($sformatf("%s_done_c%0d", tag, j), done_q[s+j], 1'b0);
      chk($sformatf("%s_busy_c%0d", tag, j), busy_q[s+j], 1'b1);
    end
    chk({tag, "_done_pulse"}, done_q[s+FLEN], 1'b1);
    chk({tag, "_busy_done"}, busy_q[s+FLEN], 1'b1);
    chk({tag, "_txd_done"}, txd_q[s+FLEN], 1'b1);
    chk({tag, "_busy_idle"}, busy_q[s+FLEN+1], 1'b0);
    chk({tag, "_txd_idle"}, txd_q[s+FLEN+1], 1'b1);
  endtask

  task automatic check_quiet(input string tag, input int from, input int to);
    for (int i = from; i <= to && i < txd_q.size(); i++) begin
      chk($sformatf("%s_txd_%0d", tag, i), txd_q[i], 1'b1);
      chk($sformatf("%s_done_%0d", tag, i), done_q[i], 1'b0);
    end
  endtask

  task automatic send_one(input string tag, input logic [7:0] d);
    int base;
    bit seen;
    seen = 1'b0;
    uart_send = 1'b1;
    send_data = d;
    base = txd_q.size();
    for (int c = 0; c < FLEN + 10 && !seen; c++) begin
      cyc(1);
      if (done_q[done_q.size()-1]) begin
        seen = 1'b1;
        uart_send = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    uart_send = 1'b0;
    cyc(8);
    check_frame(tag, base, d);
    check_quiet({tag, "_after"}, base + FLEN + 1, txd_q.size() - 1);
  endtask

  initial begin
    int base, idx, ndone;

    // reset idle
    cyc(3);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", uart_send_done, 1'b0);
    rst = 1'b1;
    base = txd_q.size();
    cyc(100);
    for (int i = base; i < base + 100; i++) begin
      chk($sformatf("idle_txd_%0d", i), txd_q[i], 1'b1);
      chk($sformatf("idle_busy_%0d", i), busy_q[i], 1'b0);
      chk($sformatf("idle_done_%0d", i), done_q[i], 1'b0);
    end

    send_one("a5", 8'hA5);
    send_one("x07", 8'h07);

    // back-to-back 0x00..0x27, controller advances on each done
    idx = 0;
    uart_send = 1'b1;
    send_data = 8'h00;
    base = txd_q.size();
    for (int c = 0; c < 40 * (FLEN + 2) + 200 && idx < 40; c++) begin
      cyc(1);
      if (done_q[done_q.size()-1]) begin
        idx++;
        if (idx == 40) uart_send = 1'b0;
        else send_data = 8'(idx);
      end
    end
    uart_send = 1'b0;
    cyc(10);
    chk("b2b_done_count", idx, 40);
    for (int k = 0; k < 40; k++)
      check_frame($sformatf("b2b%0d", k), base + k * (FLEN + 2), 8'(k));
    ndone = 0;
    for (int i = base; i < done_q.size(); i++) ndone += int'(done_q[i]);
    chk("b2b_done_total", ndone, 40);
    check_quiet("b2b_tail", base + 40 * (FLEN + 2) - 1, txd_q.size() - 1);

    // request drop + data change mid-frame
    uart_send = 1'b1;
    send_data = 8'h3C;
    base = txd_q.size();
    cyc(10);
    uart_send = 1'b0;
    send_data = 8'hFF;
    cyc(FLEN + 32 - 10);
    check_frame("drop", base, 8'h3C);
    check_quiet("drop_after", base + FLEN + 1, txd_q.size() - 1);
    ndone = 0;
    for (int i = base; i < done_q.size(); i++) ndone += int'(done_q[i]);
    chk("drop_done_total", ndone, 1);

    // reset mid-frame
    uart_send = 1'b1;
    send_data = 8'h96;
    base = txd_q.size();
    cyc(17);
    chk("abort_pre_busy", tx_busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("abort_txd", txd, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    chk("abort_done", uart_send_done, 1'b0);
    send_data = 8'h5A;
    cyc(3);
    check_quiet("abort_hold", txd_q.size() - 3, txd_q.size() - 1);
    rst = 1'b1;
    base = txd_q.size();
    cyc(FLEN + 1);
    uart_send = 1'b0;
    cyc(4);
    check_frame("restart", base, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that sits directly downstream of the byte-sequencing controller of the UART block. It accepts one byte per level-held request (`uart_send` / `send_data`), serialises it LSB-first as an 8-N-1 (optionally 8-E-1 / two stop bits) frame on `txd`, and returns a one-cycle `uart_send_done` pulse per completed frame. The controller drives the request and data ports combinationally from its state register.

## Interface
- `CLKS_PER_BIT`, 96, clock cycles per bit period (11.0592 MHz / 115200); legal range 2..65535
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `uart_send`  in  1  transmit request, level, held high by the controller until `uart_send_done` is seen
- `send_data`  in  8  byte to transmit, sampled only on the launch edge
- `uart_send_done`  out  1  one-cycle pulse, frame fully shifted out
- `txd`  out  1  serial line, idle high
- `tx_busy`  out  1  high from launch edge through the `DONE` cycle

## Operation
- Reset values: `txd`=1, `uart_send_done`=0, `tx_busy`=0, state=`IDLE`, all counters 0.
- States: `IDLE`, `START`, `DATA`, `PARITY` (macro-gated), `STOP`, `DONE`.
- `IDLE`: `txd`=1. On a rising edge with `uart_send`=1, capture `send_data` into an 8-bit shift register, set `txd`=0, go to `START`. This edge is the launch edge.
- `START`: hold `txd`=0 for `CLKS_PER_BIT` cycles, then go to `DATA` with `txd`=bit0.
- `DATA`: each bit held `CLKS_PER_BIT` cycles, LSB first. A 3-bit bit counter advances on bit-period expiry. After bit7 expires, go to `PARITY` if enabled, otherwise to `STOP`.
- `STOP`: `txd`=1 for `STOP_BITS*CLKS_PER_BIT` cycles, then go to `DONE`.
- `DONE`: `uart_send_done`=1 for exactly this one cycle, `txd`=1, then go to `IDLE` unconditionally.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1, and wrap marks the end of the bit period. It is cleared on the launch edge and on every state change.
- `uart_send` deasserting mid-frame is ignored: the frame completes and `done` still pulses.
- `send_data` changing mid-frame is ignored because the byte is latched.
- `uart_send` still high in the `DONE` cycle is ignored. It is only sampled in `IDLE`, so each request produces exactly one frame per `done`.
- Reset asserted mid-frame: `txd` returns to 1 asynchronously, the frame is abandoned, and no `done` pulse is produced.

## Timing
- Start-bit edge on `txd` is registered, appearing in the cycle after the launch edge.
- Launch edge to `uart_send_done` high: (1+8+P+`STOP_BITS`)*`CLKS_PER_BIT` cycles, where P=1 with parity and 0 without. Default: 960 cycles.
- Minimum gap between successive frames: 1 `DONE` cycle plus 1 `IDLE` cycle. Stop bit to next start bit is at least `STOP_BITS*CLKS_PER_BIT`+2 cycles.
- Controller compatibility: `done` is seen in the controller's wait state. The controller presents the next byte with the request high on the following cycle. `uart_tx` is in `IDLE` that cycle and launches on its closing edge with the new byte.

## Configuration
- `UART_TX_PARITY_EN` defined: the `PARITY` state is compiled in. After bit7, `txd` = XOR of the 8 data bits (even parity) for one bit period, then `STOP`.
- `UART_TX_PARITY_EN` undefined: no `PARITY` state and no parity logic; `DATA` goes directly to `STOP`.

## Test plan
Benches use `CLKS_PER_BIT`=4 and `STOP_BITS`=1 unless stated.
- **Reset idle:** hold `rst`=0 for 3 cycles, release with `uart_send`=0 → `txd`=1, `tx_busy`=0 and `uart_send_done`=0 for 100 cycles.
- **Single byte 0xA5:** hold `uart_send`=1 until done.
  - `txd` sequence per 4-cycle period: 0, 1,0,1,0,0,1,0,1, 1.
  - `done` pulses once, 40 cycles after the launch edge.
- **Parity build, 0x07:** `txd` shows bit pattern 1,1,1,0,0,0,0,0, then parity bit 1, then stop; `done` at 44 cycles.
- **Back-to-back 40 bytes driven by the controller model with data 0x00..0x27:**
  - Decoded bytes match in order.
  - Exactly 40 `done` pulses.
  - Every inter-frame gap is 6 cycles of `txd`=1.
- **Request drop and data change mid-frame:**
  - Drop `uart_send` and change `send_data` to 0xFF at cycle 10 of a 0x3C frame.
  - The full 0x3C frame is still sent and `done` pulses once.
  - No second frame starts.
- **Reset mid-frame:** assert `rst` at cycle 17 of a frame → `txd`=1 the same cycle, no `done`. After release with `uart_send`=1, a new full frame starts on the first edge.
